// File: rtl/scp_io_pkg.sv
// scp_io_pkg: shared constants for the SCP byte IO port.
//   SCP_N        - datapath byte width
//   SCP_IO_DEPTH - output FIFO entries (power of 2, >= 2)
//   SCP_IO_AW    - FIFO pointer width, log2(SCP_IO_DEPTH)
package scp_io_pkg;
  localparam int SCP_N        = 8;
  localparam int SCP_IO_DEPTH = 4;
  localparam int SCP_IO_AW    = $clog2(SCP_IO_DEPTH);
endpackage

// File: rtl/scp_io_fifo.sv
// scp_io_fifo: first-word fall-through synchronous FIFO with drop-on-full.
//   clk, reset   - clock, synchronous active-high reset
//   push_i/din_i - write request and data; dropped when full with no pop
//   pop_i        - read request, ignored when empty
//   dout_o       - head entry, mem[rp]
//   cnt_o        - occupancy, 0..DEPTH
//   drop_o       - this cycle's push was rejected (full, no pop)
module scp_io_fifo
  import scp_io_pkg::*;
#(
  parameter int N     = SCP_N,
  parameter int DEPTH = SCP_IO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [N-1:0]  din_i,
  input  logic          pop_i,
  output logic [N-1:0]  dout_o,
  output logic [AW:0]   cnt_o,
  output logic          drop_o
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign pop_ok  = pop_i & (cnt_q != '0);
  // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
  assign push_ok = push_i & ((cnt_q != FULL_CNT) | pop_ok);
  assign drop_o  = push_i & ~push_ok;

  // DEPTH is a power of 2, so natural pointer overflow is the wrap to 0.
  always_comb begin
    wp_d  = push_ok ? wp_q + AW'(1) : wp_q;
    rp_d  = pop_ok  ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset so the head reads 0 until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) mem_q[wp_q] <= din_i;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout_o = mem_q[rp_q];
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/scp_io_port.sv
// scp_io_port: IO-side peer of the SCP processor byte IO interface.
//   io_wr/IOout           - processor writes, queued in the output FIFO
//   host_out_*            - FIFO head to the host, valid/ready
//   host_in_*             - host bytes into the input holding register
//   io_rd/DataIn/in_empty - processor reads of the holding register
//   out_full              - output FIFO at DEPTH entries
//   overflow/underflow    - sticky error flags, cleared only by reset
module scp_io_port
  import scp_io_pkg::*;
#(
  parameter int N     = SCP_N,
  parameter int DEPTH = SCP_IO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         io_wr,
  input  logic [N-1:0] IOout,
  input  logic         io_rd,
  output logic [N-1:0] DataIn,
  output logic         in_empty,
  output logic [N-1:0] host_out_data,
  output logic         host_out_valid,
  input  logic         host_out_ready,
  input  logic [N-1:0] host_in_data,
  input  logic         host_in_valid,
  output logic         host_in_ready,
  output logic         out_full,
  output logic         overflow,
  output logic         underflow
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]  cnt;
  logic         drop;
  logic [N-1:0] in_reg_q, in_reg_d;
  logic         in_vld_q, in_vld_d;
  logic         ovf_q, ovf_d, unf_q, unf_d;
  logic         load;

  scp_io_fifo #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (io_wr),
    .din_i  (IOout),
    .pop_i  (host_out_valid & host_out_ready),
    .dout_o (host_out_data),
    .cnt_o  (cnt),
    .drop_o (drop)
  );

  assign host_out_valid = (cnt != '0);
  assign out_full       = (cnt == FULL_CNT);

  // The holding register can refill in the same cycle the processor drains it.
  assign host_in_ready = ~in_vld_q | io_rd;
  assign load          = host_in_valid & host_in_ready;

  always_comb begin
    in_reg_d = load ? host_in_data : in_reg_q;
    in_vld_d = load ? 1'b1 : (io_rd ? 1'b0 : in_vld_q);
    ovf_d    = ovf_q | drop;
    unf_d    = unf_q | (io_rd & ~in_vld_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_reg_q <= '0;
      in_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      in_reg_q <= in_reg_d;
      in_vld_q <= in_vld_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign DataIn    = in_reg_q;
  assign in_empty  = ~in_vld_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_scp_io_port.sv
// tb_scp_io_port: directed test-plan sequences followed by random traffic,
// all checked against a queue-based behavioural model of the IO port.
module tb_scp_io_port;
  localparam int N = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset, io_wr, io_rd, host_out_ready, host_in_valid;
  logic [N-1:0] IOout, host_in_data;
  logic [N-1:0] DataIn, host_out_data;
  logic         in_empty, host_out_valid, host_in_ready, out_full, overflow, underflow;

  always #5 clk = ~clk;

  scp_io_port dut (
    .clk(clk), .reset(reset), .io_wr(io_wr), .IOout(IOout), .io_rd(io_rd),
    .DataIn(DataIn), .in_empty(in_empty), .host_out_data(host_out_data),
    .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid),
    .host_in_ready(host_in_ready), .out_full(out_full),
    .overflow(overflow), .underflow(underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: output FIFO as a queue, input side as a byte + flag.
  logic [N-1:0] mq[$];
  logic [N-1:0] m_ireg;
  bit           m_ivld, m_ovf, m_unf, m_fresh;

  task automatic model_reset();
    mq.delete();
    m_ireg = '0; m_ivld = 0; m_ovf = 0; m_unf = 0; m_fresh = 1;
  endtask

  task automatic model_clock();
    bit pop, rdy;
    if (reset) begin model_reset(); return; end
    pop = (mq.size() != 0) && host_out_ready;
    if (pop) void'(mq.pop_front());
    if (io_wr) begin
      if (mq.size() < DEPTH) begin mq.push_back(IOout); m_fresh = 0; end
      else m_ovf = 1;
    end
    rdy = !m_ivld || io_rd;
    if (io_rd && !m_ivld) m_unf = 1;
    if (host_in_valid && rdy) begin m_ireg = host_in_data; m_ivld = 1; end
    else if (io_rd) m_ivld = 0;
  endtask

  task automatic check_outputs();
    chk("DataIn", DataIn, m_ireg);
    chk("in_empty", in_empty, !m_ivld);
    chk("host_out_valid", host_out_valid, mq.size() != 0);
    chk("out_full", out_full, mq.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    if (mq.size() != 0) chk("host_out_data", host_out_data, mq[0]);
    else if (m_fresh) chk("host_out_data_rst", host_out_data, 0);
  endtask

  // One clock: drive inputs, check the combinational ready, advance model + DUT.
  task automatic cyc(input bit rst, input bit wr, input logic [7:0] wd, input bit rd,
                     input bit ordy, input bit iv, input logic [7:0] id);
    reset = rst; io_wr = wr; IOout = wd; io_rd = rd;
    host_out_ready = ordy; host_in_valid = iv; host_in_data = id;
    #1;
    if (!rst) chk("host_in_ready", host_in_ready, !m_ivld || rd);
    model_clock();
    @(posedge clk); #1;
    check_outputs();
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    // Reset then idle.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_host_in_ready", host_in_ready, 1);

    // Three writes held, then drained in order.
    cyc(0, 1, 8'h11, 0, 0, 0, 0);
    chk("lat_valid", host_out_valid, 1);
    cyc(0, 1, 8'h22, 0, 0, 0, 0);
    cyc(0, 1, 8'h33, 0, 0, 0, 0);
    chk("head_11", host_out_data, 8'h11);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    chk("drained", host_out_valid, 0);

    // Five writes into a 4-deep FIFO: last dropped.
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'hA0 + 8'(i), 0, 0, 0, 0);
    chk("ovf_set", overflow, 1);
    chk("full_set", out_full, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_A", host_out_data, 8'hA0 + 8'(i));
      cyc(0, 0, 0, 0, 1, 0, 0);
    end

    // Full FIFO, push and pop together: accepted, no overflow.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 8'hB0 + 8'(i), 0, 0, 0, 0);
    cyc(0, 1, 8'hB5, 0, 1, 0, 0);
    chk("full_pp_ovf", overflow, 0);
    chk("full_pp_full", out_full, 1);
    for (int i = 2; i <= 5; i++) begin
      chk("drain_B", host_out_data, 8'hB0 + 8'(i));
      cyc(0, 0, 0, 0, 1, 0, 0);
    end

    // Input path: load, read+reload same cycle, drain, underflow.
    cyc(0, 0, 0, 0, 0, 1, 8'h5A);
    chk("din_5A", DataIn, 8'h5A);
    cyc(0, 0, 0, 1, 0, 1, 8'h6B);
    chk("din_6B", DataIn, 8'h6B);
    chk("din_6B_vld", in_empty, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("unf_set", underflow, 1);
    chk("unf_hold", DataIn, 8'h6B);

    // Reset mid-drain.
    cyc(0, 1, 8'hC1, 0, 0, 0, 0);
    cyc(0, 1, 8'hC2, 0, 1, 1, 8'h77);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("rst_valid", host_out_valid, 0);
    chk("rst_unf", underflow, 0);

    // Random traffic, biased toward filling the FIFO.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 1, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
